write_port_arbiter: RTL

Shares one write submodule between `NUM_REQ` requesters, e.g. sorter lanes writing results back to memory. Arbitration is round-robin, or fixed-priority when the round-robin macro is left undefined. The block latches the winning request's address and data, starts the write submodule, and tracks its `done` level through the write. It then returns the memory response to the winner with a one-cycle acknowledge. It sits between the sorter datapath and the write submodule's supermodule interface.

---
 rtl/write_port_arbiter_pkg.sv | 17 +
 rtl/rr_priority_picker.sv | 37 +++
 rtl/write_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/write_port_arbiter_pkg.sv
// rtl/write_port_arbiter_pkg.sv - state encodings and helpers shared by the write-port arbiter
//
// Holds the arbiter state type and its width so the future read-port
// arbiter can reuse the same encodings.
package write_port_arbiter_pkg;

    localparam int WRITE_ARB_STATE_WDTH = 3;

    typedef enum logic [WRITE_ARB_STATE_WDTH-1:0] {
        ARB_IDLE      = 3'd0,
        ARB_START     = 3'd1,
        ARB_WAIT_BUSY = 3'd2,
        ARB_WAIT_DONE = 3'd3,
        ARB_ACK       = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational first-valid picker scanning upward from a pointer with wrap
//
// Ports:
//   req_valid  in   NUM_REQ   request vector
//   ptr        in   IDX_WDTH  index where the scan starts
//   found      out  1         at least one request is valid
//   idx        out  IDX_WDTH  first valid index at or after ptr, modulo NUM_REQ
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int IDX_WDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [IDX_WDTH-1:0] ptr,
    output logic                found,
    output logic [IDX_WDTH-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // Wrap by subtraction: NUM_REQ need not be a power of two.
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                idx   = IDX_WDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/write_port_arbiter.sv
// rtl/write_port_arbiter.sv - arbitrates NUM_REQ requesters onto one shared write submodule
//
// Configuration: define WRITE_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, the pointer is fixed at 0 and the lowest valid index wins.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req_valid   in   NUM_REQ            per-requester write request (level)
//   req_addr    in   NUM_REQ*ADDR_WDTH  flattened addresses, slice i = requester i
//   req_data    in   NUM_REQ*DATA_WDTH  flattened data, slice i = requester i
//   req_ack     out  NUM_REQ            one-hot, one-cycle completion pulse
//   req_resp    out  RESP_WDTH          response, valid while req_ack is nonzero
//   sub_start   out  1                  start pulse to the write submodule
//   sub_addr    out  ADDR_WDTH          latched address to the submodule
//   sub_data    out  DATA_WDTH          latched data to the submodule
//   sub_done    in   1                  submodule idle level
//   sub_resp    in   RESP_WDTH          submodule response
//   busy        out  1                  high whenever not idle
module write_port_arbiter
    import write_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_WDTH = 4,
    parameter int DATA_WDTH = 32,
    parameter int RESP_WDTH = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDR_WDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [RESP_WDTH-1:0]           req_resp,
    output logic                           sub_start,
    output logic [ADDR_WDTH-1:0]           sub_addr,
    output logic [DATA_WDTH-1:0]           sub_data,
    input  logic                           sub_done,
    input  logic [RESP_WDTH-1:0]           sub_resp,
    output logic                           busy
);

    localparam int IDX_WDTH = $clog2(NUM_REQ);

    arb_state_e             state;
    logic [IDX_WDTH-1:0]    win_idx;
    logic [IDX_WDTH-1:0]    ptr;
    logic [IDX_WDTH-1:0]    pick_idx;
    logic                   pick_found;
    logic [ADDR_WDTH-1:0]   addr_q;
    logic [DATA_WDTH-1:0]   data_q;
    logic [RESP_WDTH-1:0]   resp_q;

    logic [ADDR_WDTH-1:0]   addr_arr [NUM_REQ];
    logic [DATA_WDTH-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_WDTH +: ADDR_WDTH];
        assign data_arr[g] = req_data[g*DATA_WDTH +: DATA_WDTH];
    end

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .IDX_WDTH (IDX_WDTH)
    ) u_picker (
        .req_valid (req_valid),
        .ptr       (ptr),
        .found     (pick_found),
        .idx       (pick_idx)
    );

`ifdef WRITE_ARB_ROUND_ROBIN_EN
    // Advance past the winner as its ack goes out, so it becomes the
    // lowest priority for the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (state == ARB_ACK) begin
            ptr <= (win_idx == IDX_WDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    assign sub_addr = addr_q;
    assign sub_data = data_q;
    // resp_q is cleared on leaving ARB_ACK, so it is nonzero only alongside req_ack.
    assign req_resp = resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            win_idx   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            resp_q    <= '0;
            req_ack   <= '0;
            sub_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found && sub_done) begin
                        state     <= ARB_START;
                        win_idx   <= pick_idx;
                        addr_q    <= addr_arr[pick_idx];
                        data_q    <= data_arr[pick_idx];
                        sub_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ARB_START: begin
                    state     <= ARB_WAIT_BUSY;
                    sub_start <= 1'b0;
                end
                ARB_WAIT_BUSY: begin
                    // The submodule must be seen leaving idle before its
                    // done level can mean completion.
                    if (!sub_done) begin
                        state <= ARB_WAIT_DONE;
                    end
                end
                ARB_WAIT_DONE: begin
                    if (sub_done) begin
                        state   <= ARB_ACK;
                        resp_q  <= sub_resp;
                        req_ack <= NUM_REQ'(1) << win_idx;
                    end
                end
                ARB_ACK: begin
                    state   <= ARB_IDLE;
                    req_ack <= '0;
                    resp_q  <= '0;
                    busy    <= 1'b0;
                end
                default: begin
                    state     <= ARB_IDLE;
                    req_ack   <= '0;
                    resp_q    <= '0;
                    sub_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
